morse_led_sequencer: RTL
========================

Name: morse_led_sequencer

Overview:
- Drives the board user LED with Morse-timed on/off sequences.
- Accepts one encoded character at a time from an upstream producer (UART decoder or pattern ROM walker) over a valid/ready handshake.
- Generates ITU Morse timing from a programmable time unit. The fixed-pattern blinkers become a thin ROM feeding this block.

Parameters:
- UNIT_CYCLES, 2000000, CLK cycles per Morse time unit (125 ms at 16 MHz); must be ≥ 2.
- CNT_W, 21, width of the unit prescaler; must satisfy 2^CNT_W ≥ UNIT_CYCLES.

Ports:
- CLK  input  1  system clock (16 MHz on TinyFPGA BX).
- RST_N  input  1  asynchronous, active-low reset.
- sym_valid  input  1  upstream character valid.
- sym_ready  output  1  block can accept a character this cycle.
- sym_len  input  3  element count 0..5; values 6..7 are clamped to 5.
- sym_bits  input  5  elements, LSB sent first; 1 = dash, 0 = dot.
- sym_word_end  input  1  character ends a word: use the word gap instead of the letter gap.
- abort  input  1  synchronous flush of the current character.
- led  output  1  LED drive, 1 = on.
- busy  output  1  character in progress (equal to ~sym_ready).

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; led = 0; busy = 0; sym_ready = 1.
  - All counters = 0; latched symbol registers = 0.
- Timing in units:
  - dot = 1 on; dash = 3 on.
  - Gap between elements of one character = 1 off.
  - Letter gap after the last element = 3 off; word gap = 7 off.
- Handshake:
  - Transfer occurs when sym_valid & sym_ready at a rising CLK edge.
  - sym_ready = 1 only in IDLE and is a pure function of state (registered, no combinational path from sym_valid).
  - On accept, sym_len, sym_bits and sym_word_end are latched. Later input changes are ignored until the next accept.
- States:
  - IDLE: led = 0. Accept with len ≥ 1 goes to MARK, element index = 0. Accept with len = 0 goes to GAP (silent character).
  - MARK: led = 1 for 1 or 3 units, chosen by bits[idx]. At the end: if idx = len−1, go to GAP; else go to SPACE.
  - SPACE: led = 0 for 1 unit; then idx += 1 and go to MARK.
  - GAP: led = 0 for 3 units (word_end = 0) or 7 units (word_end = 1); then go to IDLE.
- Latency:
  - led reflects the new state one cycle after the accepting edge.
  - First mark: led = 1 for exactly len_units × UNIT_CYCLES cycles starting the cycle after accept.
  - Every phase lasts exactly units × UNIT_CYCLES cycles; there are no bubble cycles between phases.
- Counters:
  - The prescaler counts 0..UNIT_CYCLES−1 and clears on every state entry.
  - The unit counter (3 bits, max 7) counts completed units within a phase.
  - A phase ends on the cycle where prescaler = UNIT_CYCLES−1 and unit counter = target−1.
- Back-to-back characters: sym_ready rises the cycle after GAP ends. A held sym_valid is accepted on that cycle, so inter-character spacing is exactly the gap.
- abort:
  - Takes effect at the next edge from any state: state becomes IDLE, led = 0, counters clear.
  - abort has priority over accept in the same cycle; the offered character is not consumed.
- Reset mid-character: led drops to 0 asynchronously and the character is lost.

Decomposition:
- Shared package morse_pkg holds:
  - the state enum (IDLE, MARK, SPACE, GAP);
  - constants DOT_UNITS = 1, DASH_UNITS = 3, ELEM_GAP_UNITS = 1, LETTER_GAP_UNITS = 3, WORD_GAP_UNITS = 7, MAX_LEN = 5.
- One natural sub-module: morse_unit_timer (prescaler + unit counter).
  - Inputs: start, target_units.
  - Output: done pulse.
  - Reused by future beeper/buzzer blocks.

Test Plan (UNIT_CYCLES = 4):
- Reset: assert RST_N = 0 mid-run -> led = 0, sym_ready = 1 immediately. After release, idle with no activity for 100 cycles.
- Send "S" (len 3, bits 00000, word_end 0), accepted at edge k:
  - led = 1 on cycles k+1..k+4, k+9..k+12 and k+17..k+20; 0 otherwise.
  - sym_ready = 0 through k+32; sym_ready = 1 at k+33.
- Send "O" (len 3, bits 00111) then "K" (len 3, bits 00101, word_end 1) with sym_valid held high:
  - O has three 12-cycle marks separated by 4-cycle spaces.
  - K is accepted exactly 12 cycles after O's last mark.
  - After K, busy persists 28 cycles past its last mark.
- len = 0 with word_end = 1 -> led stays 0; busy for exactly 28 cycles; no marks.
- Clamp: len = 7, bits 11111 -> exactly 5 dashes (5 × 12 cycles on).
- abort asserted during the second mark of "S", while sym_valid is high with a new character:
  - Next cycle: led = 0 and state is IDLE; the new character is not accepted on the abort cycle.
  - The new character is accepted on the following cycle.

Source files
------------

// File: rtl/morse_led_sequencer_pkg.sv
// Purpose : Shared types and Morse timing constants for the LED sequencer and
//           for future beeper/buzzer blocks that reuse the unit timer.
// Contents: state_e (sequencer FSM states), unit counts per Morse element,
//           MAX_LEN, and clamp_len() which limits the element count to MAX_LEN.
package morse_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMark,
        StSpace,
        StGap
    } state_e;

    localparam logic [2:0] DOT_UNITS        = 3'd1;
    localparam logic [2:0] DASH_UNITS       = 3'd3;
    localparam logic [2:0] ELEM_GAP_UNITS   = 3'd1;
    localparam logic [2:0] LETTER_GAP_UNITS = 3'd3;
    localparam logic [2:0] WORD_GAP_UNITS   = 3'd7;
    localparam logic [2:0] MAX_LEN          = 3'd5;

    // Lengths 6 and 7 do not fit the 5-bit element field; treat them as 5.
    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

endpackage

// File: rtl/morse_led_sequencer_if.sv
// Purpose : Character handshake between an upstream producer (UART decoder,
//           pattern ROM walker) and the Morse LED sequencer.
// Signals : sym_valid    - producer offers a character
//           sym_ready    - sequencer can take a character this cycle
//           sym_len      - element count 0..7 (6..7 are treated as 5)
//           sym_bits     - elements, LSB first, 1 = dash, 0 = dot
//           sym_word_end - character closes a word (word gap instead of letter gap)
// Modports: master = producer side, slave = sequencer side.
interface morse_led_sequencer_if;

    logic       sym_valid;
    logic       sym_ready;
    logic [2:0] sym_len;
    logic [4:0] sym_bits;
    logic       sym_word_end;

    modport master (
        output sym_valid,
        output sym_len,
        output sym_bits,
        output sym_word_end,
        input  sym_ready
    );

    modport slave (
        input  sym_valid,
        input  sym_len,
        input  sym_bits,
        input  sym_word_end,
        output sym_ready
    );

endinterface

// File: rtl/morse_unit_timer.sv
// Purpose : Measures a phase of target_units Morse time units.
//           A prescaler counts 0..UNIT_CYCLES-1; a 3-bit unit counter counts
//           completed units. done is high on the last cycle of the phase.
// Ports   : CLK, RST_N  - clock, async active-low reset
//           start        - clear both counters at the next edge (phase entry)
//           target_units - phase length in units, 1..7
//           done         - last cycle of the phase
module morse_unit_timer #(
    parameter int unsigned UNIT_CYCLES = 2000000,
    parameter int unsigned CNT_W       = 21
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       start,
    input  logic [2:0] target_units,
    output logic       done
);

    localparam logic [CNT_W-1:0] PreLast = CNT_W'(UNIT_CYCLES - 1);

    logic [CNT_W-1:0] r_pre;
    logic [CNT_W-1:0] w_pre_d;
    logic [2:0]       r_unit;
    logic [2:0]       w_unit_d;
    logic             w_pre_wrap;

    assign w_pre_wrap = (r_pre == PreLast);
    assign done       = w_pre_wrap && (r_unit == (target_units - 3'd1));

    always_comb begin
        w_pre_d  = r_pre + 1'b1;
        w_unit_d = r_unit;
        if (start) begin
            w_pre_d  = '0;
            w_unit_d = '0;
        end else if (w_pre_wrap) begin
            w_pre_d  = '0;
            w_unit_d = r_unit + 3'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pre  <= '0;
            r_unit <= '0;
        end else begin
            r_pre  <= w_pre_d;
            r_unit <= w_unit_d;
        end
    end

endmodule

// File: rtl/morse_led_sequencer.sv
// Purpose : Plays one Morse character at a time on the user LED with ITU timing
//           (dot 1, dash 3, element gap 1, letter gap 3, word gap 7 units).
// Ports   : CLK, RST_N - clock, async active-low reset
//           sym         - character handshake (slave side)
//           abort       - synchronous flush back to idle; wins over an accept
//           led         - LED drive, 1 = on
//           busy        - character in progress (~sym_ready)
module morse_led_sequencer
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 2000000,
    parameter int unsigned CNT_W       = 21
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    morse_led_sequencer_if.slave  sym,
    input  logic                  abort,
    output logic                  led,
    output logic                  busy
);

    state_e     r_state;
    state_e     w_state_d;
    logic [2:0] r_len;
    logic [2:0] w_len_d;
    logic [4:0] r_bits;
    logic [4:0] w_bits_d;
    logic       r_word_end;
    logic       w_word_end_d;
    logic [2:0] r_idx;
    logic [2:0] w_idx_d;

    logic       w_accept;
    logic [2:0] w_len_in;
    logic [2:0] w_target;
    logic       w_start;
    logic       w_done;

    // Outputs depend on the registered state only.
    assign sym.sym_ready = (r_state == StIdle);
    assign busy          = ~sym.sym_ready;
    assign led           = (r_state == StMark);

    assign w_accept = sym.sym_valid && sym.sym_ready && !abort;
    assign w_len_in = clamp_len(sym.sym_len);

    always_comb begin
        w_target = DOT_UNITS;
        unique case (r_state)
            StMark:  w_target = r_bits[r_idx] ? DASH_UNITS : DOT_UNITS;
            StSpace: w_target = ELEM_GAP_UNITS;
            StGap:   w_target = r_word_end ? WORD_GAP_UNITS : LETTER_GAP_UNITS;
            default: w_target = DOT_UNITS;
        endcase
    end

    always_comb begin
        w_state_d    = r_state;
        w_len_d      = r_len;
        w_bits_d     = r_bits;
        w_word_end_d = r_word_end;
        w_idx_d      = r_idx;
        if (abort) begin
            w_state_d = StIdle;
            w_idx_d   = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        w_len_d      = w_len_in;
                        w_bits_d     = sym.sym_bits;
                        w_word_end_d = sym.sym_word_end;
                        w_idx_d      = '0;
                        // A zero-length character only produces its gap.
                        w_state_d    = (w_len_in == 3'd0) ? StGap : StMark;
                    end
                end
                StMark: begin
                    if (w_done) begin
                        w_state_d = (r_idx == (r_len - 3'd1)) ? StGap : StSpace;
                    end
                end
                StSpace: begin
                    if (w_done) begin
                        w_idx_d   = r_idx + 3'd1;
                        w_state_d = StMark;
                    end
                end
                StGap: begin
                    if (w_done) begin
                        w_state_d = StIdle;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    // Every state change restarts the timer; holding it cleared in idle keeps
    // the counters at zero between characters.
    assign w_start = (w_state_d != r_state) || (w_state_d == StIdle);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= StIdle;
            r_len      <= '0;
            r_bits     <= '0;
            r_word_end <= 1'b0;
            r_idx      <= '0;
        end else begin
            r_state    <= w_state_d;
            r_len      <= w_len_d;
            r_bits     <= w_bits_d;
            r_word_end <= w_word_end_d;
            r_idx      <= w_idx_d;
        end
    end

    morse_unit_timer #(
        .UNIT_CYCLES (UNIT_CYCLES),
        .CNT_W       (CNT_W)
    ) u_timer (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .start        (w_start),
        .target_units (w_target),
        .done         (w_done)
    );

endmodule
